fg_prog_sequencer: RTL and testbench
====================================

# fg_prog_sequencer

Digital programming sequencer that drives the row/column programming infrastructure of one floating-gate island: the vertical and horizontal VinjDecode address inputs, drain-select, programming-switch and gate-mux enables, and the injection/tunnelling pulse lines. It accepts one programming or read command at a time over a valid/ready handshake. For each command it steps through address setup, a timed pulse train with settle gaps, and release. It sits between the chip's configuration controller and the island's decoder/switch tiles.

## Interface
- ROW_BITS, 2, vertical decoder address width
- COL_BITS, 4, horizontal decoder address width
- CNT_W, 8, pulse-count width
- PULSE_W, 16, pulse-width counter width
- SETTLE_CYC, 8, settle cycles for setup, gap and release (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, command accepted when valid&ready
- cmd_row  in  ROW_BITS  target row
- cmd_col  in  COL_BITS  target column
- cmd_mode  in  2  00 inject, 01 tunnel, 10 read, 11 illegal
- cmd_pulses  in  CNT_W  number of pulses
- cmd_width  in  PULSE_W  pulse width in cycles (0 treated as 1)
- abort  in  1  terminate current command (only with FG_PROG_ABORT_EN)
- vdec_addr / hdec_addr  out  ROW_BITS / COL_BITS  decoder addresses
- vdec_en / hdec_en  out  1  decoder enables
- drain_sel, prog_sw, gate_mux_en  out  1  switch-tile controls
- inj_pulse, tun_pulse  out  1  programming pulses
- meas_strobe  out  1  one-cycle readback strobe
- busy  out  1  state ≠ IDLE
- done, err  out  1  one-cycle completion / error flags

## Operation
- States: IDLE, SETUP, PULSE, GAP, MEAS, RELEASE, DONE.
- IDLE: cmd_ready=1. On accept, register row/col/mode/pulses/width and go to SETUP. With mode 11, instead pulse err for 1 cycle and stay in IDLE.
- SETUP (SETTLE_CYC cycles): addresses and both decoder enables are driven.
  - Inject: drain_sel=1, prog_sw=1, gate_mux_en=1.
  - Tunnel: prog_sw=1 only.
  - Read: drain_sel=1, gate_mux_en=1.
- SETUP exit: read → MEAS; pulses=0 → RELEASE; otherwise → PULSE.
- PULSE (width cycles): inj_pulse (inject) or tun_pulse (tunnel) high. Decrement the remaining count, then go to GAP if count>0, else RELEASE.
- GAP (SETTLE_CYC cycles): pulses low, then return to PULSE.
- MEAS (1 cycle): meas_strobe=1, then RELEASE.
- RELEASE (SETTLE_CYC cycles): pulses low, addresses and enables held.
- DONE (1 cycle): all controls low, done=1, cmd_ready=0. Next state is IDLE.
- Pulse lines are never high outside PULSE. Enables and addresses never change between SETUP and RELEASE.

## Timing
- All outputs registered. Reset values: every output 0, including cmd_ready; state IDLE.
- cmd_ready rises on the first cycle after reset release.
- Cycle numbering: the accept edge is cycle 0; controls are asserted from cycle 1.
- Inject/tunnel total: S + N·W + (N−1)·S + S cycles with controls asserted, then DONE. Here S = SETTLE_CYC, N = pulses, W = width.
- Read total: S + 1 + S cycles, then DONE.
- cmd_valid while busy is ignored; there is no queuing.
- Reset asserted mid-command: all outputs clear immediately (asynchronously) and no done is issued.

## Configuration
- FG_PROG_ABORT_EN defined: abort port exists.
  - abort high in SETUP/PULSE/GAP/MEAS → RELEASE next cycle, with pulse lines low from that cycle.
  - The command then ends in DONE with done=1 and err=1 together.
  - abort in IDLE/RELEASE/DONE is ignored.
- Undefined: no abort port; commands always run to completion.

## Structure
- Shared package fg_prog_pkg holds:
  - the state enum and mode enum (MODE_INJ, MODE_TUN, MODE_READ, MODE_BAD);
  - the default SETTLE_CYC constant.
- Sub-module fg_prog_timer: loadable down-counter with expire flag. It is shared by the settle and pulse-width timing.

## Test plan
- Reset → all outputs 0; cmd_ready=1 one cycle after rst_n rises.
- Inject, row 2, col 9, N=3, W=5, S=8:
  - vdec_addr=2, hdec_addr=9 on cycles 1–47;
  - inj_pulse high on cycles 9–13, 22–26 and 35–39;
  - done on cycle 48.
- Read, row 1, col 3: meas_strobe on cycle 9 only; done on cycle 18; inj_pulse/tun_pulse never high.
- Tunnel with N=0 → no pulses, prog_sw high on cycles 1–16, done on cycle 17. Mode 11 → err on cycle 1, busy stays 0.
- Command with cmd_valid held during busy → the second command is accepted only on the cycle after DONE. rst_n dropped mid-PULSE → outputs 0 immediately, no done.
- FG_PROG_ABORT_EN: abort during the second pulse → inj_pulse low the next cycle, followed by RELEASE for 8 cycles, then done=1 and err=1 in the same cycle.

Source files
------------

// File: rtl/fg_prog_pkg.sv
// Shared types and defaults for the floating-gate programming sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fg_prog_pkg;

    // Settle length used for the setup, gap and release phases unless overridden.
    localparam int SETTLE_CYC_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_MEAS,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Encoding matches the cmd_mode input field directly.
    typedef enum logic [1:0] {
        MODE_INJ  = 2'b00,
        MODE_TUN  = 2'b01,
        MODE_READ = 2'b10,
        MODE_BAD  = 2'b11
    } mode_t;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter with an expire flag, shared by settle and pulse-width timing.
// Latency: a load of V makes o_expire rise V cycles after the load edge.
// Backpressure: none; a load always wins over counting.
module fg_prog_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Row/column programming sequencer for one floating-gate island; optional abort via FG_PROG_ABORT_EN.
// Latency: controls from the cycle after accept; S + N*W + (N-1)*S + S (or S+1+S for read) cycles, then DONE.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, nothing is queued.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int ROW_BITS   = 2,
    parameter int COL_BITS   = 4,
    parameter int CNT_W      = 8,
    parameter int PULSE_W    = 16,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [1:0]          cmd_mode,
    input  logic [CNT_W-1:0]    cmd_pulses,
    input  logic [PULSE_W-1:0]  cmd_width,
`ifdef FG_PROG_ABORT_EN
    input  logic                abort,
`endif
    output logic [ROW_BITS-1:0] vdec_addr,
    output logic [COL_BITS-1:0] hdec_addr,
    output logic                vdec_en,
    output logic                hdec_en,
    output logic                drain_sel,
    output logic                prog_sw,
    output logic                gate_mux_en,
    output logic                inj_pulse,
    output logic                tun_pulse,
    output logic                meas_strobe,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // The settle length shares the pulse-width timer, so it must fit in PULSE_W bits.
    localparam logic [PULSE_W-1:0] SETTLE_M1 = PULSE_W'(SETTLE_CYC - 1);

    state_t               r_state;
    state_t               w_nxt;
    mode_t                r_mode;
    mode_t                w_mode;
    mode_t                w_cmd_mode;
    logic [ROW_BITS-1:0]  r_row;
    logic [ROW_BITS-1:0]  w_row;
    logic [COL_BITS-1:0]  r_col;
    logic [COL_BITS-1:0]  w_col;
    logic [CNT_W-1:0]     r_left;
    logic [PULSE_W-1:0]   r_wm1;
    logic [PULSE_W-1:0]   w_tmr_val;
    logic                 w_tmr_load;
    logic                 w_expire;
    logic                 r_aborted;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_bad;
    logic                 w_abort;
    logic                 w_active;

    fg_prog_timer #(
        .W(PULSE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_val    (w_tmr_val),
        .o_expire (w_expire)
    );

`ifdef FG_PROG_ABORT_EN
    // Abort only counts while the island is being driven before release.
    assign w_abort = abort && ((r_state == ST_SETUP) || (r_state == ST_PULSE) ||
                               (r_state == ST_GAP)   || (r_state == ST_MEAS));
`else
    assign w_abort = 1'b0;
`endif

    assign w_cmd_mode = mode_t'(cmd_mode);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_start    = w_accept && (w_cmd_mode != MODE_BAD);
    assign w_bad      = w_accept && (w_cmd_mode == MODE_BAD);

    // Outputs are registered from next state, so the accepting edge must see the new command fields.
    assign w_mode = w_start ? w_cmd_mode : r_mode;
    assign w_row  = w_start ? cmd_row    : r_row;
    assign w_col  = w_start ? cmd_col    : r_col;

    // Next-state decode and timer reload on every timed phase entry.
    always_comb begin
        w_nxt      = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt      = ST_SETUP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_M1;
                end
            end
            ST_SETUP: begin
                if (w_expire) begin
                    if (r_mode == MODE_READ) begin
                        w_nxt = ST_MEAS;
                    end else if (r_left == '0) begin
                        w_nxt      = ST_RELEASE;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = SETTLE_M1;
                    end else begin
                        w_nxt      = ST_PULSE;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = r_wm1;
                    end
                end
            end
            ST_PULSE: begin
                if (w_expire) begin
                    w_nxt      = (r_left > CNT_W'(1)) ? ST_GAP : ST_RELEASE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_M1;
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    w_nxt      = ST_PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = r_wm1;
                end
            end
            ST_MEAS: begin
                w_nxt      = ST_RELEASE;
                w_tmr_load = 1'b1;
                w_tmr_val  = SETTLE_M1;
            end
            ST_RELEASE: begin
                if (w_expire) begin
                    w_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt = ST_IDLE;
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_nxt      = ST_RELEASE;
            w_tmr_load = 1'b1;
            w_tmr_val  = SETTLE_M1;
        end
    end

    // Addresses and enables are held from SETUP through RELEASE.
    assign w_active = (w_nxt != ST_IDLE) && (w_nxt != ST_DONE);

    // State, captured command and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_INJ;
            r_row       <= '0;
            r_col       <= '0;
            r_left      <= '0;
            r_wm1       <= '0;
            r_aborted   <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            vdec_addr   <= '0;
            hdec_addr   <= '0;
            vdec_en     <= 1'b0;
            hdec_en     <= 1'b0;
            drain_sel   <= 1'b0;
            prog_sw     <= 1'b0;
            gate_mux_en <= 1'b0;
            inj_pulse   <= 1'b0;
            tun_pulse   <= 1'b0;
            meas_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_start) begin
                r_mode    <= w_cmd_mode;
                r_row     <= cmd_row;
                r_col     <= cmd_col;
                r_left    <= cmd_pulses;
                r_wm1     <= (cmd_width == '0) ? '0 : cmd_width - PULSE_W'(1);
                r_aborted <= 1'b0;
            end else if ((r_state == ST_PULSE) && w_expire) begin
                r_left <= r_left - CNT_W'(1);
            end
            if (w_abort) begin
                r_aborted <= 1'b1;
            end
            cmd_ready   <= (w_nxt == ST_IDLE);
            busy        <= (w_nxt != ST_IDLE);
            vdec_addr   <= w_active ? w_row : '0;
            hdec_addr   <= w_active ? w_col : '0;
            vdec_en     <= w_active;
            hdec_en     <= w_active;
            drain_sel   <= w_active && ((w_mode == MODE_INJ) || (w_mode == MODE_READ));
            prog_sw     <= w_active && ((w_mode == MODE_INJ) || (w_mode == MODE_TUN));
            gate_mux_en <= w_active && ((w_mode == MODE_INJ) || (w_mode == MODE_READ));
            inj_pulse   <= (w_nxt == ST_PULSE) && (w_mode == MODE_INJ);
            tun_pulse   <= (w_nxt == ST_PULSE) && (w_mode == MODE_TUN);
            meas_strobe <= (w_nxt == ST_MEAS);
            done        <= (w_nxt == ST_DONE);
            err         <= w_bad || ((w_nxt == ST_DONE) && r_aborted);
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: timeline model per command plus literal spot checks.
// Latency: n/a.
// Backpressure: commands are held on cmd_valid until the model says the sequencer is idle.
module tb_fg_prog_sequencer;

    localparam int S     = 8;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic [1:0] va;
        logic [3:0] ha;
        logic       ve;
        logic       he;
        logic       dr;
        logic       ps;
        logic       gm;
        logic       inj;
        logic       tun;
        logic       ms;
        logic       dn;
        logic       er;
    } ov_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_row = '0;
    logic [3:0]  cmd_col = '0;
    logic [1:0]  cmd_mode = '0;
    logic [7:0]  cmd_pulses = '0;
    logic [15:0] cmd_width = '0;
`ifdef FG_PROG_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        cmd_ready, busy, vdec_en, hdec_en, drain_sel, prog_sw, gate_mux_en;
    logic        inj_pulse, tun_pulse, meas_strobe, done, err;
    logic [1:0]  vdec_addr;
    logic [3:0]  hdec_addr;

    fg_prog_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_mode    (cmd_mode),
        .cmd_pulses  (cmd_pulses),
        .cmd_width   (cmd_width),
`ifdef FG_PROG_ABORT_EN
        .abort       (abort),
`endif
        .vdec_addr   (vdec_addr),
        .hdec_addr   (hdec_addr),
        .vdec_en     (vdec_en),
        .hdec_en     (hdec_en),
        .drain_sel   (drain_sel),
        .prog_sw     (prog_sw),
        .gate_mux_en (gate_mux_en),
        .inj_pulse   (inj_pulse),
        .tun_pulse   (tun_pulse),
        .meas_strobe (meas_strobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    ov_t  cur;
    assign cur = {cmd_ready, busy, vdec_addr, hdec_addr, vdec_en, hdec_en, drain_sel,
                  prog_sw, gate_mux_en, inj_pulse, tun_pulse, meas_strobe, done, err};

    ov_t  exp_a [DEPTH];
    ov_t  obs_a [DEPTH];
    logic abl   [DEPTH];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic in_rst = 1'b1;

    function automatic ov_t idle_v();
        ov_t v;
        v     = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    task automatic init_model();
        for (int i = 0; i < DEPTH; i++) begin
            exp_a[i] = idle_v();
            obs_a[i] = '0;
            abl[i]   = 1'b0;
        end
        exp_a[0] = '0;
        cyc      = 0;
    endtask

    // Expand one accepted command (accept cycle k) into its expected output timeline.
    task automatic fill(input int k, input logic [1:0] row, input logic [3:0] col,
                        input logic [1:0] mode, input int n, input int w);
        ov_t a;
        int  t;
        int  wd;
        if (mode == 2'b11) begin
            exp_a[k+1].er = 1'b1;
            return;
        end
        wd     = (w == 0) ? 1 : w;
        a      = '0;
        a.busy = 1'b1;
        a.va   = row;
        a.ha   = col;
        a.ve   = 1'b1;
        a.he   = 1'b1;
        a.dr   = (mode != 2'b01);
        a.gm   = (mode != 2'b01);
        a.ps   = (mode != 2'b10);
        t      = k + 1;
        repeat (S) begin exp_a[t] = a; abl[t] = 1'b1; t++; end
        if (mode == 2'b10) begin
            exp_a[t] = a; exp_a[t].ms = 1'b1; abl[t] = 1'b1; t++;
        end else begin
            for (int p = 0; p < n; p++) begin
                repeat (wd) begin
                    exp_a[t] = a;
                    exp_a[t].inj = (mode == 2'b00);
                    exp_a[t].tun = (mode == 2'b01);
                    abl[t] = 1'b1;
                    t++;
                end
                if (p < n - 1) begin
                    repeat (S) begin exp_a[t] = a; abl[t] = 1'b1; t++; end
                end
            end
        end
        repeat (S) begin exp_a[t] = a; abl[t] = 1'b0; t++; end
        exp_a[t] = '0; exp_a[t].busy = 1'b1; exp_a[t].dn = 1'b1; abl[t] = 1'b0;
    endtask

`ifdef FG_PROG_ABORT_EN
    // Abort seen in cycle k: release with pulses dropped, then done+err, then idle.
    task automatic do_abort(input int k);
        ov_t a;
        int  t;
        a     = exp_a[k];
        a.inj = 1'b0; a.tun = 1'b0; a.ms = 1'b0;
        t     = k + 1;
        repeat (S) begin exp_a[t] = a; abl[t] = 1'b0; t++; end
        exp_a[t] = '0; exp_a[t].busy = 1'b1; exp_a[t].dn = 1'b1; exp_a[t].er = 1'b1;
        abl[t] = 1'b0; t++;
        for (int i = t; i < t + 200 && i < DEPTH; i++) begin exp_a[i] = idle_v(); abl[i] = 1'b0; end
    endtask
`endif

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (in_rst) begin
            tests++;
            if (cur !== '0) begin
                fails++;
                $display("FAIL reset_outputs t=%0t got=%h want=0", $time, cur);
            end
        end else begin
            obs_a[cyc] = cur;
            tests++;
            if (cur !== exp_a[cyc]) begin
                fails++;
                $display("FAIL cycle_%0d outputs got=%h want=%h", cyc, cur, exp_a[cyc]);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Advance one cycle, updating the model for whatever the DUT samples at this edge.
    task automatic step();
        if (cmd_valid && exp_a[cyc].rdy)
            fill(cyc, cmd_row, cmd_col, cmd_mode, int'(cmd_pulses), int'(cmd_width));
`ifdef FG_PROG_ABORT_EN
        if (abort && abl[cyc]) do_abort(cyc);
`endif
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [1:0] row, input logic [3:0] col, input logic [1:0] mode,
                        input int n, input int w, input bit hold, output int acc);
        cmd_row = row; cmd_col = col; cmd_mode = mode;
        cmd_pulses = 8'(n); cmd_width = 16'(w); cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (exp_a[cyc].rdy) acc = cyc;
            step();
        end
        if (!hold) cmd_valid = 1'b0;
        if (acc < 0) begin
            tests++; fails++;
            $display("FAIL accept_timeout cyc=%0d", cyc);
            acc = cyc;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, cnt;
        init_model();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        init_model();
        in_rst = 1'b0;
        rst_n  = 1'b1;
        steps(3);
        chk("ready_before_edge", int'(obs_a[0].rdy), 0);
        chk("ready_first_cycle", int'(obs_a[1].rdy), 1);

        // Inject row 2 col 9, N=3 W=5
        send(2'd2, 4'd9, 2'b00, 3, 5, 1'b0, k);
        steps(52);
        chk("inj_vaddr_c1",  int'(obs_a[k+1].va), 2);
        chk("inj_haddr_c47", int'(obs_a[k+47].ha), 9);
        chk("inj_vaddr_c48", int'(obs_a[k+48].va), 0);
        chk("inj_pulse_c8",  int'(obs_a[k+8].inj), 0);
        chk("inj_pulse_c9",  int'(obs_a[k+9].inj), 1);
        chk("inj_pulse_c13", int'(obs_a[k+13].inj), 1);
        chk("inj_pulse_c14", int'(obs_a[k+14].inj), 0);
        chk("inj_pulse_c22", int'(obs_a[k+22].inj), 1);
        chk("inj_pulse_c39", int'(obs_a[k+39].inj), 1);
        chk("inj_pulse_c40", int'(obs_a[k+40].inj), 0);
        chk("inj_done_c47",  int'(obs_a[k+47].dn), 0);
        chk("inj_done_c48",  int'(obs_a[k+48].dn), 1);

        // Read row 1 col 3
        send(2'd1, 4'd3, 2'b10, 4, 2, 1'b0, k);
        steps(22);
        chk("rd_meas_c8",  int'(obs_a[k+8].ms), 0);
        chk("rd_meas_c9",  int'(obs_a[k+9].ms), 1);
        chk("rd_meas_c10", int'(obs_a[k+10].ms), 0);
        chk("rd_done_c18", int'(obs_a[k+18].dn), 1);
        cnt = 0;
        for (int i = 1; i <= 18; i++) cnt += int'(obs_a[k+i].inj) + int'(obs_a[k+i].tun);
        chk("rd_no_pulses", cnt, 0);

        // Tunnel with zero pulses
        send(2'd3, 4'd15, 2'b01, 0, 4, 1'b0, k);
        steps(20);
        chk("tun0_ps_c1",   int'(obs_a[k+1].ps), 1);
        chk("tun0_ps_c16",  int'(obs_a[k+16].ps), 1);
        chk("tun0_ps_c17",  int'(obs_a[k+17].ps), 0);
        chk("tun0_done_17", int'(obs_a[k+17].dn), 1);

        // Illegal mode
        send(2'd1, 4'd1, 2'b11, 1, 1, 1'b0, k);
        steps(3);
        chk("bad_err_c1",  int'(obs_a[k+1].er), 1);
        chk("bad_busy_c1", int'(obs_a[k+1].busy), 0);
        chk("bad_err_c2",  int'(obs_a[k+2].er), 0);

        // Zero width counts as one cycle; tunnel with two pulses
        send(2'd0, 4'd6, 2'b00, 2, 0, 1'b0, k);
        steps(30);
        chk("w0_pulse_c9",  int'(obs_a[k+9].inj), 1);
        chk("w0_pulse_c10", int'(obs_a[k+10].inj), 0);
        send(2'd2, 4'd4, 2'b01, 2, 3, 1'b0, k);
        steps(40);

        // cmd_valid held through a read: next command waits until after DONE
        send(2'd1, 4'd3, 2'b10, 0, 1, 1'b1, k);
        send(2'd0, 4'd5, 2'b00, 1, 2, 1'b0, k2);
        chk("held_accept_gap", k2 - k, 19);
        steps(30);

`ifdef FG_PROG_ABORT_EN
        // Abort during the second pulse of an inject command
        send(2'd2, 4'd9, 2'b00, 3, 5, 1'b0, k);
        while (cyc < k + 23) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        steps(14);
        chk("abort_inj_c23",  int'(obs_a[k+23].inj), 1);
        chk("abort_inj_c24",  int'(obs_a[k+24].inj), 0);
        chk("abort_en_c31",   int'(obs_a[k+31].ve), 1);
        chk("abort_done_c32", int'(obs_a[k+32].dn), 1);
        chk("abort_err_c32",  int'(obs_a[k+32].er), 1);
`endif

        // Reset dropped mid-PULSE
        send(2'd3, 4'd10, 2'b00, 2, 20, 1'b0, k);
        while (cyc < k + 12) step();
        chk("pre_rst_pulse", int'(inj_pulse), 1);
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        chk("rst_mid_outputs", int'(cur), 0);
        repeat (2) @(posedge clk);
        #1;
        init_model();
        in_rst = 1'b0;
        rst_n  = 1'b1;
        steps(40);
        cnt = 0;
        for (int i = 0; i < 40; i++) cnt += int'(obs_a[i].dn);
        chk("rst_no_done", cnt, 0);
        chk("rst_ready_c1", int'(obs_a[1].rdy), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
